biquad8_wb_initiator: RTL and testbench

Single-outstanding Wishbone classic-cycle initiator that turns a valid/ready command stream of register reads and writes into bus cycles and returns one response per command. It drives the register port of the biquad8 filter wrapper: coefficient writes, update strobes and readback. It replaces hand-written bus tasks with a synthesizable master, so a controller, or a bench driving the command stream, can program the filter. It uses one clock and holds at most one transaction in flight.

---
 rtl/biquad8_wb_initiator.sv | 159 +++++++++++++++
 tb/tb_biquad8_wb_initiator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad8_wb_initiator.sv
// rtl/biquad8_wb_initiator.sv - single-outstanding Wishbone classic initiator driven by a cmd/rsp stream
module biquad8_wb_initiator #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rstn_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_we_i,
    input  logic [ADDR_BITS-1:0]   cmd_adr_i,
    input  logic [DATA_BITS-1:0]   cmd_dat_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DATA_BITS-1:0]   rsp_dat_o,
    output logic                   rsp_err_o,
    output logic                   busy_o,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [DATA_BITS/8-1:0] wb_sel_o,
    output logic [ADDR_BITS-1:0]   wb_adr_o,
    output logic [DATA_BITS-1:0]   wb_dat_o,
    input  logic [DATA_BITS-1:0]   wb_dat_i,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i
);

    localparam int SEL_BITS = DATA_BITS / 8;
    localparam int CNT_BITS = $clog2(TIMEOUT + 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   busy_q, busy_d;
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [SEL_BITS-1:0]    sel_q, sel_d;
    logic [ADDR_BITS-1:0]   adr_q, adr_d;
    logic [DATA_BITS-1:0]   dat_q, dat_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0]   rsp_dat_q, rsp_dat_d;
    logic                   rsp_err_q, rsp_err_d;

    // Next-state and registered-output logic; everything holds unless a transition updates it
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                // Ready is registered, so the handshake uses the visible ready level
                if (cmd_valid_i && cmd_ready_q) begin
                    state_d     = S_BUS;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    cyc_d       = 1'b1;
                    we_d        = cmd_we_i;
                    sel_d       = '1;
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    cnt_d       = '0;
                end else begin
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + CNT_BITS'(1);
                if (wb_err_i || wb_ack_i || (cnt_q == CNT_LAST)) begin
                    state_d     = S_RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = '0;
                    adr_d       = '0;
                    dat_d       = '0;
                    rsp_valid_d = 1'b1;
                    // Error wins over ack; a timeout (neither) is also an error
                    rsp_err_d   = wb_err_i || !wb_ack_i;
                    rsp_dat_d   = (wb_ack_i && !wb_err_i && !we_q) ? wb_dat_i : '0;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    rsp_valid_d = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction silently
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign busy_o      = busy_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_biquad8_wb_initiator.sv
// tb/tb_biquad8_wb_initiator.sv - directed self-checking bench for biquad8_wb_initiator
module tb_biquad8_wb_initiator;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we = 1'b0;
    logic [6:0]  cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid_o;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [6:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i;

    int          n_checks = 0;
    int          n_fail = 0;

    // Slave model controls
    logic        slave_silent = 1'b0;
    logic        slave_both = 1'b0;
    logic [3:0]  slave_wait = 4'd0;
    logic [31:0] slave_rdata = 32'h0;
    logic [3:0]  wcnt = 4'd0;

    // Monitors
    logic [6:0]  wr_adr [0:7];
    logic [31:0] wr_dat [0:7];
    logic [3:0]  wr_sel [0:7];
    int          wr_n = 0;
    logic        busy_viol = 1'b0;

    biquad8_wb_initiator #(.ADDR_BITS(7), .DATA_BITS(32), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    assign wb_ack_i = wb_cyc_o && wb_stb_o && !slave_silent && (wcnt == slave_wait);
    assign wb_err_i = wb_cyc_o && wb_stb_o && slave_both && (wcnt == slave_wait);
    assign wb_dat_i = slave_rdata;

    always @(posedge clk) begin
        if (!wb_stb_o) wcnt <= 4'd0;
        else           wcnt <= wcnt + 4'd1;
    end

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o && wr_n < 8) begin
            wr_adr[wr_n] <= wb_adr_o;
            wr_dat[wr_n] <= wb_dat_o;
            wr_sel[wr_n] <= wb_sel_o;
            wr_n <= wr_n + 1;
        end
        if (cmd_valid && cmd_ready_o && busy_o) busy_viol <= 1'b1;
    end

    task automatic run_cmd(input logic we, input logic [6:0] a, input logic [31:0] d,
                           output int stb_n, output logic [31:0] rd, output logic re,
                           output logic stable, output logic ok);
        int k;
        ok = 1'b1; stable = 1'b1; stb_n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = a; cmd_dat = d;
        k = 0;
        while (cmd_ready_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (wb_stb_o === 1'b1 && k < 100) begin
            stb_n++;
            if (wb_adr_o !== a || wb_we_o !== we || wb_cyc_o !== 1'b1 || wb_sel_o !== 4'hF ||
                (we && wb_dat_o !== d)) stable = 1'b0;
            @(negedge clk);
            k++;
        end
        rd = rsp_dat_o; re = rsp_err_o;
        if (rsp_valid_o !== 1'b1) ok = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (cmd_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready_o); end
        n_checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc_stb: got %b%b expected 00", wb_cyc_o, wb_stb_o); end
        n_checks++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_busy: got %b%b expected 00", rsp_valid_o, busy_o); end
        n_checks++; if (wb_sel_o !== 4'h0 || wb_adr_o !== 7'h0) begin n_fail++; $display("FAIL reset_sel_adr: got %h %h expected 0 0", wb_sel_o, wb_adr_o); end
        rstn = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready_o); end
    endtask

    task automatic test_write_seq();
        int start, k, sn;
        logic [31:0] rd; logic re, st, ok;
        start = wr_n;
        slave_wait = 4'd0; slave_silent = 1'b0; slave_both = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 7'h04; cmd_dat = 32'd16384;
        k = 0;
        while (cmd_ready_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        n_checks++; if (k >= 50) begin n_fail++; $display("FAIL wr0_accept: got timeout expected ready"); end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111 || wb_sel_o !== 4'hF) begin n_fail++; $display("FAIL wr0_bus_ctl: got %b%b%b sel %h expected 111 sel f", wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o); end
        n_checks++; if (wb_adr_o !== 7'h04 || wb_dat_o !== 32'h4000) begin n_fail++; $display("FAIL wr0_bus_adr_dat: got %h %h expected 04 00004000", wb_adr_o, wb_dat_o); end
        n_checks++; if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL wr0_busy: got ready %b busy %b expected 0 1", cmd_ready_o, busy_o); end
        @(negedge clk);
        n_checks++; if (wb_cyc_o !== 1'b0 || wb_sel_o !== 4'h0 || wb_adr_o !== 7'h0) begin n_fail++; $display("FAIL wr0_term_bus: got cyc %b sel %h adr %h expected 0 0 0", wb_cyc_o, wb_sel_o, wb_adr_o); end
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_dat_o !== 32'h0) begin n_fail++; $display("FAIL wr0_rsp: got v%b e%b d%h expected v1 e0 d0", rsp_valid_o, rsp_err_o, rsp_dat_o); end
        @(negedge clk);
        n_checks++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL wr0_idle: got v%b r%b c%b expected v0 r1 c0", rsp_valid_o, cmd_ready_o, wb_cyc_o); end
        run_cmd(1'b1, 7'h04, 32'd8192, sn, rd, re, st, ok);
        n_checks++; if (!ok || re !== 1'b0 || rd !== 32'h0 || !st) begin n_fail++; $display("FAIL wr1_rsp: got ok%b e%b d%h st%b expected ok1 e0 d0 st1", ok, re, rd, st); end
        run_cmd(1'b1, 7'h00, 32'd1, sn, rd, re, st, ok);
        n_checks++; if (!ok || re !== 1'b0 || rd !== 32'h0 || !st) begin n_fail++; $display("FAIL wr2_rsp: got ok%b e%b d%h st%b expected ok1 e0 d0 st1", ok, re, rd, st); end
        n_checks++; if (wr_n !== start + 3) begin n_fail++; $display("FAIL wr_count: got %0d expected %0d", wr_n - start, 3); end
        else begin
            n_checks++; if (wr_adr[start] !== 7'h04 || wr_dat[start] !== 32'h4000 || wr_sel[start] !== 4'hF) begin n_fail++; $display("FAIL wr_log0: got %h %h %h expected 04 00004000 f", wr_adr[start], wr_dat[start], wr_sel[start]); end
            n_checks++; if (wr_adr[start+1] !== 7'h04 || wr_dat[start+1] !== 32'h2000 || wr_sel[start+1] !== 4'hF) begin n_fail++; $display("FAIL wr_log1: got %h %h %h expected 04 00002000 f", wr_adr[start+1], wr_dat[start+1], wr_sel[start+1]); end
            n_checks++; if (wr_adr[start+2] !== 7'h00 || wr_dat[start+2] !== 32'h1 || wr_sel[start+2] !== 4'hF) begin n_fail++; $display("FAIL wr_log2: got %h %h %h expected 00 00000001 f", wr_adr[start+2], wr_dat[start+2], wr_sel[start+2]); end
        end
        n_checks++; if (busy_viol !== 1'b0) begin n_fail++; $display("FAIL accept_while_busy: got %b expected 0", busy_viol); end
    endtask

    task automatic test_read_wait();
        int sn; logic [31:0] rd; logic re, st, ok;
        slave_wait = 4'd3; slave_rdata = 32'hDEADBEEF;
        run_cmd(1'b0, 7'h10, 32'h0, sn, rd, re, st, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_wait_done: got no response expected response"); end
        n_checks++; if (sn !== 4) begin n_fail++; $display("FAIL rd_wait_stb_cycles: got %0d expected 4", sn); end
        n_checks++; if (rd !== 32'hDEADBEEF || re !== 1'b0) begin n_fail++; $display("FAIL rd_wait_rsp: got d%h e%b expected deadbeef e0", rd, re); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL rd_wait_stable: got %b expected 1", st); end
        slave_wait = 4'd0;
    endtask

    task automatic test_timeout();
        int sn; logic [31:0] rd; logic re, st, ok;
        slave_silent = 1'b1; slave_rdata = 32'h55AA55AA;
        run_cmd(1'b0, 7'h20, 32'h0, sn, rd, re, st, ok);
        n_checks++; if (sn !== 8) begin n_fail++; $display("FAIL timeout_stb_cycles: got %0d expected 8", sn); end
        n_checks++; if (!ok || re !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL timeout_rsp: got ok%b e%b d%h expected ok1 e1 d0", ok, re, rd); end
        slave_silent = 1'b0; slave_rdata = 32'h12345678;
        run_cmd(1'b0, 7'h21, 32'h0, sn, rd, re, st, ok);
        n_checks++; if (!ok || re !== 1'b0 || rd !== 32'h12345678 || sn !== 1) begin n_fail++; $display("FAIL after_timeout_rsp: got ok%b e%b d%h stb%0d expected ok1 e0 d12345678 stb1", ok, re, rd, sn); end
    endtask

    task automatic test_ack_err();
        int sn; logic [31:0] rd; logic re, st, ok;
        slave_both = 1'b1; slave_rdata = 32'hFFFF0000;
        run_cmd(1'b0, 7'h30, 32'h0, sn, rd, re, st, ok);
        n_checks++; if (!ok || re !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL ack_err_rsp: got ok%b e%b d%h expected ok1 e1 d0", ok, re, rd); end
        slave_both = 1'b0;
    endtask

    task automatic test_backpressure();
        int k; logic [31:0] ref_d; logic ref_e; logic held;
        slave_rdata = 32'hCAFEF00D; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 7'h08; cmd_dat = 32'h0;
        k = 0;
        while (cmd_ready_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        cmd_we = 1'b1; cmd_adr = 7'h0C; cmd_dat = 32'h0000_0077;
        k = 0;
        while (rsp_valid_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        n_checks++; if (k >= 50) begin n_fail++; $display("FAIL bp_rsp_arrive: got timeout expected rsp_valid"); end
        ref_d = rsp_dat_o; ref_e = rsp_err_o;
        n_checks++; if (ref_d !== 32'hCAFEF00D || ref_e !== 1'b0) begin n_fail++; $display("FAIL bp_rsp_value: got d%h e%b expected cafef00d e0", ref_d, ref_e); end
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid_o !== 1'b1 || rsp_dat_o !== ref_d || rsp_err_o !== ref_e ||
                cmd_ready_o !== 1'b0 || wb_cyc_o !== 1'b0) held = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %b expected 1", held); end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL bp_release: got v%b r%b c%b expected v0 r1 c0", rsp_valid_o, cmd_ready_o, wb_cyc_o); end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 7'h0C || wb_we_o !== 1'b1 || wb_dat_o !== 32'h77) begin n_fail++; $display("FAIL bp_pending_accept: got c%b a%h w%b d%h expected c1 a0c w1 d77", wb_cyc_o, wb_adr_o, wb_we_o, wb_dat_o); end
        k = 0;
        while (rsp_valid_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        n_checks++; if (rsp_err_o !== 1'b0 || rsp_dat_o !== 32'h0 || k >= 50) begin n_fail++; $display("FAIL bp_pending_rsp: got e%b d%h expected e0 d0", rsp_err_o, rsp_dat_o); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_bus();
        int k; logic seen;
        slave_silent = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 7'h04; cmd_dat = 32'h1111;
        k = 0;
        while (cmd_ready_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (wb_stb_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_stb: got %b expected 1", wb_stb_o); end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_checks++; if ({wb_cyc_o, wb_stb_o, cmd_ready_o, rsp_valid_o, busy_o} !== 5'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got %b expected 00000", {wb_cyc_o, wb_stb_o, cmd_ready_o, rsp_valid_o, busy_o}); end
        @(negedge clk);
        n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", cmd_ready_o); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_o !== 1'b0 || wb_cyc_o !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_rsp: got %b expected 0", seen); end
        slave_silent = 1'b0;
    endtask

    task automatic test_after_reset();
        int sn; logic [31:0] rd; logic re, st, ok;
        slave_rdata = 32'h0BADCAFE;
        run_cmd(1'b0, 7'h7F, 32'h0, sn, rd, re, st, ok);
        n_checks++; if (!ok || re !== 1'b0 || rd !== 32'h0BADCAFE || !st) begin n_fail++; $display("FAIL post_reset_read: got ok%b e%b d%h st%b expected ok1 e0 d0badcafe st1", ok, re, rd, st); end
    endtask

    initial begin
        test_reset();
        test_write_seq();
        test_read_wait();
        test_timeout();
        test_ack_err();
        test_backpressure();
        test_reset_mid_bus();
        test_after_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
